// File: rtl/gpio_input_capture_pkg.sv
// Shared definitions for the GPIO input capture block: register selects,
// address field position and default debounce depth.
package gpio_input_capture_pkg;

    typedef enum logic [1:0] {
        REG_LEVEL   = 2'd0,
        REG_PENDING = 2'd1,
        REG_RISE_EN = 2'd2,
        REG_FALL_EN = 2'd3
    } reg_sel_e;

    localparam int ADDR_SEL_HI      = 3;
    localparam int ADDR_SEL_LO      = 2;
    localparam int DEBOUNCE_DEFAULT = 4;

    function automatic reg_sel_e decode_sel(input logic [31:0] addr);
        return reg_sel_e'(addr[ADDR_SEL_HI:ADDR_SEL_LO]);
    endfunction

endpackage

// File: rtl/gpio_input_capture_debounce.sv
// Single-pin two-flop synchronizer, debounce filter and edge pulse generator.
// rise/fall are asserted in the cycle before the filtered level flips.
module gpio_debounce
    import gpio_input_capture_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic             sync_p0;
    logic             sync_p1;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             accept;

    // Counter only ever holds DEBOUNCE-1 at most; the DEBOUNCE-th differing cycle accepts.
    assign differ = sync_p1 ^ level_q;
    assign accept = differ && (cnt_q == CNT_W'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_p0 <= pin_in;
            sync_p1 <= sync_p0;
            if (accept) begin
                level_q <= sync_p1;
                cnt_q   <= '0;
            end else if (differ) begin
                cnt_q   <= cnt_q + 1'b1;
            end else begin
                cnt_q   <= '0;
            end
        end
    end

    assign level = level_q;
    assign rise  = accept & sync_p1;
    assign fall  = accept & ~sync_p1;

endmodule

// File: rtl/gpio_input_capture.sv
// GPIO input capture: per-pin debounce, sticky edge pending bits with W1C,
// rise/fall enables, bus register file and level interrupt.
module gpio_input_capture
    import gpio_input_capture_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] pins_in,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] rd_sel;
    reg_sel_e         sel;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .pin_in (pins_in[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign sel          = decode_sel(address);
    assign wr_data      = write_data[WIDTH-1:0];
    assign unused_wdata = &{1'b0, write_data[31:WIDTH]};

    // Set is OR-ed in after the clear so a same-cycle edge wins over W1C.
    assign set_mask = (rise & rise_en_q) | (fall & fall_en_q);
    assign clr_mask = (write && sel == REG_PENDING) ? wr_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
            if (write && sel == REG_RISE_EN) begin
                rise_en_q <= wr_data;
            end
            if (write && sel == REG_FALL_EN) begin
                fall_en_q <= wr_data;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (read) begin
            case (sel)
                REG_LEVEL:   rd_sel = level;
                REG_PENDING: rd_sel = pending_q;
                REG_RISE_EN: rd_sel = rise_en_q;
                REG_FALL_EN: rd_sel = fall_en_q;
                default:     rd_sel = '0;
            endcase
        end
    end

    assign read_data = {{(32 - WIDTH){1'b0}}, rd_sel};
    assign irq       = |pending_q;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture (WIDTH=8, DEBOUNCE=4).
module tb_gpio_input_capture;

    localparam logic [31:0] A_LEVEL   = 32'h0;
    localparam logic [31:0] A_PENDING = 32'h4;
    localparam logic [31:0] A_RISE_EN = 32'h8;
    localparam logic [31:0] A_FALL_EN = 32'hC;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  pins_in;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_input_capture #(
        .WIDTH    (8),
        .DEBOUNCE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .pins_in    (pins_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        #1;
        d       = read_data;
        read    = 1'b0;
        address = '0;
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        write_data = d;
        write      = 1'b1;
        tick(1);
        write      = 1'b0;
        write_data = '0;
        address    = '0;
    endtask

    initial begin
        logic [31:0] d;
        reset      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        write_data = '0;
        pins_in    = 8'h00;

        // Reset held: pins toggle, everything stays cleared.
        tick(2);
        pins_in = 8'hFF;
        tick(2);
        pins_in = 8'h00;
        tick(2);
        pins_in = 8'hFF;
        tick(3);
        check_reg("rst_level", A_LEVEL, 32'h0);
        check_reg("rst_pending", A_PENDING, 32'h0);
        check_reg("rst_rise_en", A_RISE_EN, 32'h0);
        check_reg("rst_fall_en", A_FALL_EN, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rdata_idle", read_data, 32'h0);

        // Release: high pins debounced as 0->1, no pending since enables are 0.
        reset = 1'b1;
        tick(5);
        check_reg("rel_level_early", A_LEVEL, 32'h0);
        tick(1);
        check_reg("rel_level", A_LEVEL, 32'hFF);
        check_reg("rel_pending", A_PENDING, 32'h0);

        pins_in = 8'h00;
        tick(10);
        check_reg("low_level", A_LEVEL, 32'h0);

        // Rising capture on pin0 with exact latency.
        bus_write(A_RISE_EN, 32'h01);
        pins_in = 8'h01;
        tick(5);
        check_reg("rise_level_early", A_LEVEL, 32'h0);
        check_reg("rise_pend_early", A_PENDING, 32'h0);
        chk("rise_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check_reg("rise_level", A_LEVEL, 32'h01);
        check_reg("rise_pending", A_PENDING, 32'h01);
        chk("rise_irq", {31'b0, irq}, 32'h1);

        // W1C sequence from PENDING=0x81.
        bus_write(A_RISE_EN, 32'h81);
        pins_in = 8'h81;
        tick(8);
        check_reg("w1c_start", A_PENDING, 32'h81);
        bus_write(A_PENDING, 32'h01);
        check_reg("w1c_bit0", A_PENDING, 32'h80);
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        bus_write(A_PENDING, 32'h80);
        check_reg("w1c_bit7", A_PENDING, 32'h0);
        chk("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // Glitch of 3 cycles on pin3 is rejected.
        bus_write(A_RISE_EN, 32'hFF);
        bus_write(A_FALL_EN, 32'hFF);
        pins_in = 8'h89;
        tick(3);
        pins_in = 8'h81;
        tick(10);
        check_reg("glitch_level", A_LEVEL, 32'h81);
        check_reg("glitch_pending", A_PENDING, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        // Clear/set collision on pin2 falling edge.
        pins_in = 8'h85;
        tick(8);
        check_reg("coll_rise", A_PENDING, 32'h04);
        bus_write(A_PENDING, 32'h04);
        check_reg("coll_cleared", A_PENDING, 32'h0);
        pins_in = 8'h81;
        tick(5);
        bus_write(A_PENDING, 32'h04);
        check_reg("coll_level", A_LEVEL, 32'h81);
        check_reg("coll_set_wins", A_PENDING, 32'h04);

        // Disabling an enable keeps an existing pending bit.
        bus_write(A_FALL_EN, 32'h00);
        check_reg("dis_fall_en", A_FALL_EN, 32'h0);
        check_reg("dis_keep_pend", A_PENDING, 32'h04);
        chk("dis_irq", {31'b0, irq}, 32'h1);

        // Bus decode: width masking, RO LEVEL, idle read data.
        bus_write(A_RISE_EN, 32'hFFFF_FF5A);
        check_reg("mask_rise_en", A_RISE_EN, 32'h0000_005A);
        bus_write(A_LEVEL, 32'h0000_0000);
        check_reg("level_ro", A_LEVEL, 32'h81);
        address = A_RISE_EN;
        read    = 1'b0;
        #1;
        chk("rdata_idle", read_data, 32'h0);

        // Simultaneous read and write: pre-write value, then new value.
        address    = A_RISE_EN;
        write_data = 32'h11;
        write      = 1'b1;
        read       = 1'b1;
        #1;
        chk("rw_prewrite", read_data, 32'h5A);
        tick(1);
        write = 1'b0;
        read  = 1'b0;
        bus_read(A_RISE_EN, d);
        chk("rw_postwrite", d, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_input_capture.md
# gpio_input_capture

Input-side companion to the GPIO output/direction peripheral: it samples the external pins, synchronizes and debounces them, and detects rising and falling edges into sticky pending bits. It sits on the same simple peripheral bus (read/write strobes, 32-bit address and data) and raises a level interrupt to the core while any enabled edge is pending.

## Interface
- WIDTH, 8: number of pins captured; valid range 1..31.
- DEBOUNCE, 4: consecutive synchronized cycles a new level must hold before it is accepted; ≥1.

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- read  input  1  bus read strobe
- write  input  1  bus write strobe
- address  input  32  byte address; only address[3:2] decoded
- write_data  input  32  bus write data
- read_data  output  32  bus read data, zero-extended above WIDTH
- pins_in  input  WIDTH  raw asynchronous pin levels
- irq  output  1  level interrupt, high while any pending bit is set

## Operation
- Register map, selected by address[3:2]:
  - 0 LEVEL (RO): debounced pin levels.
  - 1 PENDING (R/W1C): sticky edge flags; writing 1 clears a bit, writing 0 has no effect.
  - 2 RISE_EN (RW): enables capture of rising edges per pin.
  - 3 FALL_EN (RW): enables capture of falling edges per pin.
- Writes to LEVEL are ignored. write_data bits above WIDTH are ignored; read_data bits above WIDTH are 0.
- Per-pin pipeline: two-flop synchronizer, then debounce, then edge detect.
- Debounce: a per-pin counter counts cycles where the synchronized value differs from the filtered value. It resets to 0 whenever the two values agree. When the count reaches DEBOUNCE, the filtered bit takes the new value and the counter clears.
- Edge detect: on the same clock edge the filtered bit changes, PENDING[i] is set if the change is 0→1 with RISE_EN[i]=1, or 1→0 with FALL_EN[i]=1.
- Simultaneous W1C and new edge on the same bit: the set wins, and the bit stays 1.
- Disabling an enable bit does not clear an already pending bit.
- irq = OR of PENDING, combinational from the registered pending bits.
- read_data is combinational: the selected register when read=1, otherwise 0. Reads have no side effects.
- Simultaneous read and write: read_data shows the pre-write value, and the write takes effect at the clock edge.

## Timing
- Reset (reset=0, asynchronous) clears the synchronizers, filtered levels, counters, PENDING, RISE_EN and FALL_EN to 0. As a result, irq=0 and read_data=0 (with read=0).
- Assertion of reset mid-debounce aborts the count. After release, pins already high are debounced as a 0→1 change, but no pending bit is set because the enables are 0.
- Pin-to-level latency: a pin change stable before clock edge k appears in LEVEL after edge k+1+DEBOUNCE. That is two synchronizer edges (k, k+1), then DEBOUNCE counting edges. The PENDING bit and irq update on that same edge.
- A glitch shorter than DEBOUNCE synchronized cycles produces no LEVEL change and no pending bit.
- Register writes take effect on the clock edge where write=1 and are visible to a read in the next cycle.
- The bus has no wait states; every access completes in one cycle.

## Structure
- Shared package/header: register offset constants (LEVEL=0, PENDING=1, RISE_EN=2, FALL_EN=3), the address field slice [3:2], and the default DEBOUNCE.
- One natural sub-module, gpio_debounce: a single-pin synchronizer, debounce counter and edge pulse (rise/fall outputs). Instantiate it as an array of WIDTH instances.
- The top level holds the register file, W1C logic, read mux and irq OR.

## Test plan
- Reset: hold reset=0, toggle pins_in=8'hFF -> all registers read 0, irq=0. Release reset -> after 2+4 edges LEVEL=8'hFF and PENDING=0.
- Rising capture: write RISE_EN=8'h01, drive pin0 0→1 -> LEVEL[0] and PENDING=8'h01 set exactly 6 edges after the change, with irq=1 on that edge.
- Glitch rejection: pulse pin3 high for 3 cycles with DEBOUNCE=4 and RISE_EN=FALL_EN=8'hFF -> LEVEL and PENDING stay 0.
- W1C: with PENDING=8'h81, write PENDING with 32'h01 -> PENDING=8'h80 and irq stays 1. Write 32'h80 -> PENDING=0 and irq=0.
- Clear/set collision: schedule a W1C of bit2 on the same edge that pin2's falling edge is accepted (FALL_EN[2]=1) -> PENDING[2]=1 afterwards.
- Bus decode: write RISE_EN=32'hFFFF_FF5A -> reads back 32'h0000_005A. Write to LEVEL -> no change. With read=0, read_data=0.
